// File: rtl/branch_predictor.sv
// Direct-mapped, tagged 2-bit-counter branch predictor with same-cycle lookup/train forwarding.
// Optional lookup/mispredict statistics counters are built when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int unsigned ENTRIES  = 32,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bp_enable,
  input  logic                guess_valid,
  input  logic [PC_WIDTH-1:0] guess_pc,
  output logic                guess_taken,
  input  logic                check_valid,
  input  logic [PC_WIDTH-1:0] check_pc,
  input  logic                check_taken,
  input  logic                check_guess,
  output logic [31:0]         stat_lookups,
  output logic [31:0]         stat_mispredicts
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_WIDTH - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX-1:0]   chk_idx;
  logic [TAG_W-1:0] chk_tag;
  logic             chk_hit;
  logic             upd_en;
  logic [1:0]       upd_ctr;

  logic [IDX-1:0]   gs_idx;
  logic [TAG_W-1:0] gs_tag;
  logic             fwd;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [1:0]       rd_ctr;

  // Training: next counter value for the entry addressed by check_pc
  always_comb begin
    chk_idx = check_pc[IDX+1:2];
    chk_tag = check_pc[PC_WIDTH-1:IDX+2];
    upd_en  = check_valid & bp_enable;
    chk_hit = valid_q[chk_idx] & (tag_q[chk_idx] == chk_tag);
    upd_ctr = ctr_q[chk_idx];
    if (chk_hit) begin
      if (check_taken) begin
        upd_ctr = (ctr_q[chk_idx] == 2'b11) ? 2'b11 : ctr_q[chk_idx] + 2'(1);
      end else begin
        upd_ctr = (ctr_q[chk_idx] == 2'b00) ? 2'b00 : ctr_q[chk_idx] - 2'(1);
      end
    end else begin
      upd_ctr = check_taken ? 2'b10 : 2'b01;
    end
  end

  // Lookup: a same-index training write is forwarded into the read
  always_comb begin
    gs_idx   = guess_pc[IDX+1:2];
    gs_tag   = guess_pc[PC_WIDTH-1:IDX+2];
    fwd      = upd_en & (chk_idx == gs_idx);
    rd_valid = valid_q[gs_idx];
    rd_tag   = tag_q[gs_idx];
    rd_ctr   = ctr_q[gs_idx];
    if (fwd) begin
      rd_valid = 1'b1;
      rd_tag   = chk_tag;
      rd_ctr   = upd_ctr;
    end
    guess_taken = bp_enable & guess_valid & rd_valid & (rd_tag == gs_tag) & rd_ctr[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else if (upd_en) begin
      valid_q[chk_idx] <= 1'b1;
      tag_q[chk_idx]   <= chk_tag;
      ctr_q[chk_idx]   <= upd_ctr;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] mispredicts_q;
  logic        unused_pc_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      if (guess_valid & bp_enable) begin
        lookups_q <= lookups_q + 32'(1);
      end
      if (upd_en & (check_guess != check_taken)) begin
        mispredicts_q <= mispredicts_q + 32'(1);
      end
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispredicts_q;
  assign unused_pc_bits   = ^{guess_pc[1:0], check_pc[1:0]};
`else
  logic unused_pc_bits;

  assign stat_lookups     = '0;
  assign stat_mispredicts = '0;
  assign unused_pc_bits   = ^{guess_pc[1:0], check_pc[1:0], check_guess};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed plan followed by random traffic,
// checked against a table model indexed with plain PC arithmetic.
module tb_branch_predictor;

  localparam int unsigned ENT = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bp_enable = 1'b0;
  logic        guess_valid = 1'b0;
  logic [31:0] guess_pc = '0;
  logic        guess_taken;
  logic        check_valid = 1'b0;
  logic [31:0] check_pc = '0;
  logic        check_taken = 1'b0;
  logic        check_guess = 1'b0;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;

  branch_predictor #(.ENTRIES(ENT), .PC_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .bp_enable(bp_enable),
    .guess_valid(guess_valid), .guess_pc(guess_pc), .guess_taken(guess_taken),
    .check_valid(check_valid), .check_pc(check_pc), .check_taken(check_taken),
    .check_guess(check_guess), .stat_lookups(stat_lookups),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

`ifdef BP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    bit          has_guess;
    bit          g;
    logic [31:0] lk;
    logic [31:0] mp;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference table: index = (pc/4) mod ENT, tag = pc / (4*ENT), ctr in 0..3
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  int          m_ctr   [ENT];
  int unsigned cnt_lk = 0;
  int unsigned cnt_mp = 0;

  function automatic void model_reset();
    for (int i = 0; i < int'(ENT); i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_ctr[i]   = 1;
    end
    cnt_lk = 0;
    cnt_mp = 0;
  endfunction

  function automatic bit model_lookup(input logic [31:0] pc);
    int unsigned i = (pc / 4) % ENT;
    return m_valid[i] && (m_tag[i] == pc / (4 * ENT)) && (m_ctr[i] >= 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus; model applies training before lookup, which yields the
  // post-update value for the same index and is irrelevant for other indices.
  task automatic cyc(input bit gv, input logic [31:0] gpc, input bit cv,
                     input logic [31:0] cpc, input bit ct, input bit cg, input bit en);
    exp_t e;
    int unsigned i;
    @(posedge clk);
    #1;
    bp_enable = en; guess_valid = gv; guess_pc = gpc;
    check_valid = cv; check_pc = cpc; check_taken = ct; check_guess = cg;
    e.lk = STATS ? 32'(cnt_lk) : 32'd0;
    e.mp = STATS ? 32'(cnt_mp) : 32'd0;
    if (cv && en) begin
      i = (cpc / 4) % ENT;
      if (m_valid[i] && m_tag[i] == cpc / (4 * ENT)) begin
        m_ctr[i] = ct ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      end else begin
        m_valid[i] = 1'b1;
        m_tag[i]   = cpc / (4 * ENT);
        m_ctr[i]   = ct ? 2 : 1;
      end
      if (cg != ct) cnt_mp++;
    end
    e.has_guess = gv;
    e.g = en && gv && model_lookup(gpc);
    if (gv && en) cnt_lk++;
    sbq.push_back(e);
  endtask

  // Monitor: compares once per cycle, half a period after inputs settle
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.has_guess) chk("guess_taken", 32'(guess_taken), 32'(e.g));
      chk("stat_lookups", stat_lookups, e.lk);
      chk("stat_mispredicts", stat_mispredicts, e.mp);
    end
  end

  // Asynchronous reset in the middle of a cycle, checked before any clock edge
  task automatic mid_cycle_reset(input logic [31:0] pc);
    @(posedge clk);
    #1;
    bp_enable = 1'b1; guess_valid = 1'b1; guess_pc = pc; check_valid = 1'b0;
    #1;
    chk("pre_reset_guess", 32'(guess_taken), 32'(model_lookup(pc)));
    rst_n = 1'b0;
    #1;
    chk("async_rst_guess", 32'(guess_taken), 32'd0);
    chk("async_rst_lookups", stat_lookups, 32'd0);
    chk("async_rst_mispredicts", stat_mispredicts, 32'd0);
    model_reset();
    guess_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state and allocation/saturation
    cyc(1, 32'h1000, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h1000, 1, 0, 1);
    cyc(1, 32'h1000, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h1000, 1, 1, 1);
    cyc(0, 0, 1, 32'h1000, 1, 1, 1);
    cyc(1, 32'h1000, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h1000, 0, 1, 1);
    cyc(1, 32'h1000, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h1000, 0, 1, 1);
    cyc(1, 32'h1000, 0, 0, 0, 0, 1);
    // aliasing on the same index
    cyc(0, 0, 1, 32'h1000, 1, 0, 1);
    cyc(0, 0, 1, 32'h1080, 0, 0, 1);
    cyc(1, 32'h1000, 0, 0, 0, 0, 1);
    cyc(1, 32'h1080, 0, 0, 0, 0, 1);
    // same-cycle forwarding
    cyc(0, 0, 1, 32'h2000, 0, 0, 1);
    cyc(1, 32'h2000, 1, 32'h2000, 1, 0, 1);
    // disable freezes the table
    repeat (3) cyc(0, 0, 1, 32'h3000, 1, 0, 1);
    cyc(1, 32'h3000, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 32'h3000, 1, 32'h3000, 0, 1, 0);
    cyc(1, 32'h3000, 0, 0, 0, 0, 1);
    // mispredict accounting
    repeat (5) cyc(0, 0, 1, 32'h4000, 1, 0, 1);
    repeat (2) cyc(0, 0, 1, 32'h4000, 1, 1, 1);
    cyc(1, 32'h4000, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    mid_cycle_reset(32'h3000);
    cyc(1, 32'h3000, 0, 0, 0, 0, 1);
    cyc(1, 32'h1000, 0, 0, 0, 0, 1);

    // random traffic over a small PC pool so hits, aliases and forwarding all occur
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] gpc, cpc;
      gpc = 32'h1000 + (32'($urandom_range(0, 3)) << 7) + (32'($urandom_range(0, 7)) << 2);
      cpc = 32'h1000 + (32'($urandom_range(0, 3)) << 7) + (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 3) == 0) cpc = gpc;
      cyc(1'($urandom), gpc, 1'($urandom), cpc, 1'($urandom), 1'($urandom),
          $urandom_range(0, 9) != 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);

    repeat (4) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the RV32 CPU core, sitting directly upstream of fetch PC selection. Fetch presents the PC of the instruction being fetched and receives a same-cycle taken/not-taken guess. Execute later reports the resolved outcome, which trains a direct-mapped, tagged table of 2-bit saturating counters. The block is gated by the core's `bp_enable` input. When disabled, it always predicts not-taken and ignores training.

## Interface
- `ENTRIES`, 32, number of table entries; power of two, 4..256.
- `PC_WIDTH`, 32, PC width in bits.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bp_enable`  in  1  predictor enable (from the top-level `bp_enable`).
- `guess_valid`  in  1  fetch requests a prediction this cycle.
- `guess_pc`  in  PC_WIDTH  PC of the fetched branch.
- `guess_taken`  out  1  prediction; combinational from `guess_pc`.
- `check_valid`  in  1  execute reports a resolved conditional branch.
- `check_pc`  in  PC_WIDTH  PC of the resolved branch.
- `check_taken`  in  1  actual outcome.
- `check_guess`  in  1  prediction originally issued for this branch.
- `stat_lookups`  out  32  count of predictions issued (only with BP_STATS_EN).
- `stat_mispredicts`  out  32  count of mispredicts (only with BP_STATS_EN).

## Operation
- **Index and tag.**
  - Index = `pc[IDX+1:2]`, where IDX = log2(ENTRIES).
  - Tag = `pc[PC_WIDTH-1:IDX+2]`.
- **Entry contents.** Each entry holds `valid`, `tag`, and a 2-bit counter `ctr`.
  - Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Lookup.**
  - hit = `valid` & (tag match).
  - `guess_taken` = `bp_enable` & `guess_valid` & hit & `ctr[1]`.
  - A miss predicts not-taken.
- **Training.** Applies when `check_valid` & `bp_enable`, at the next rising edge.
  - Hit, taken: `ctr` += 1, saturating at 11.
  - Hit, not-taken: `ctr` -= 1, saturating at 00.
  - Miss: allocate the entry. Set `valid`=1, write the new tag, and set `ctr` = 10 if taken, else 01. The previous occupant is overwritten.
- **Disabled.** With `bp_enable`=0:
  - `guess_taken`=0.
  - The table is frozen; contents are retained for re-enable.
- **Same-cycle forwarding.** If `guess_valid` and `check_valid` are both set in one cycle and index the same entry, the lookup uses the post-update entry value (the new tag/counter as computed above).
- **Independent entries.** Updates to different indices in the same cycle as a lookup do not affect the lookup.
- **Reset.** `rst_n`=0 clears all `valid` and sets all `ctr`=01, asynchronously. It also clears the stat counters. Reset mid-training discards the pending update.

## Timing
- Lookup is zero-latency (combinational). It must meet timing for a single-cycle read from a flop array; no SRAM macros.
- Training takes effect at the rising edge where `check_valid`=1. It is visible to a non-forwarded lookup from the next cycle.
- Reset value of every output:
  - `guess_taken`=0, because the table is all-invalid after reset.
  - `stat_lookups`=0.
  - `stat_mispredicts`=0.
- No back-pressure: both ports accept one request per cycle, every cycle.
- `check_*` may arrive any number of cycles after the corresponding lookup. There is no ordering requirement between them.

## Configuration
- **`BP_STATS_EN` defined:**
  - `stat_lookups` increments on every cycle with `guess_valid` & `bp_enable`.
  - `stat_mispredicts` increments on every cycle with `check_valid` & `bp_enable` & (`check_guess` != `check_taken`).
  - Both counters are 32-bit and wrap modulo 2^32.
  - A lookup and a mispredict in the same cycle each increment their own counter.
- **`BP_STATS_EN` undefined:**
  - Both stat ports are tied to 0.
  - No counter flops are generated.

## Test plan
- **Reset.** Reset, then look up pc=0x1000 with `bp_enable`=1 -> `guess_taken`=0. With BP_STATS_EN, one cycle later `stat_lookups`=1.
- **Allocation and saturation.** Send check pc=0x1000, taken=1 -> next lookup of 0x1000 gives 1 (ctr=10). Two more taken -> ctr=11. Then one not-taken -> still 1 (ctr=10). A second not-taken -> 0 (ctr=01).
- **Aliasing** (ENTRIES=32). Train 0x1000 taken, then check 0x1080 not-taken (same index, different tag) -> lookup 0x1000 misses and gives 0; lookup 0x1080 gives 0 (ctr=01).
- **Forwarding.** With entry 0x2000 at ctr=01, in one cycle apply guess_pc=0x2000 and check_pc=0x2000, taken=1 -> `guess_taken`=1 in that same cycle.
- **Disable.** Train 0x3000 to ctr=11, then drop `bp_enable` -> lookup gives 0. Send 3 not-taken checks while disabled, then re-enable -> lookup gives 1 (table unchanged).
- **Stats and async reset** (BP_STATS_EN). Send 5 checks with `check_guess` != `check_taken` and 2 matching -> `stat_mispredicts`=5. Assert `rst_n` low mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
